phase_timer_fsm: RTL
====================

Name: phase_timer_fsm

Overview:
Parametrised multi-phase sequencer with a built-in phase timer. It steps through NUM_PHASES timed phases, each with its own programmable length, then ends in DONE or loops back to phase 0. It serves as the game's generic sequencing engine: turn timers, intro/animation phases, and PS/2 mouse init delays. It adds start/pause/abort control, a tick prescaler and per-phase completion pulses.

Parameters:
TIMER_W, 8, width of the phase timer and of each phase length field
NUM_PHASES, 4, number of timed phases (2..16)
PRESCALE, 1, clock cycles per timer tick (1 = every cycle; ≥1)
LOOP, 0, 0 = stop in DONE after last phase; 1 = wrap to phase 0

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  level; begins sequence from IDLE or DONE
pause  in  1  level; freezes timer and prescaler while high
abort  in  1  level; returns to IDLE
phase_len  in  NUM_PHASES*TIMER_W  length of phase k in bits [k*TIMER_W +: TIMER_W]
state  out  NUM_PHASES+2  one-hot: bit0 IDLE, bit k+1 PHASE_k, bit NUM_PHASES+1 DONE
phase_idx  out  clog2(NUM_PHASES)  index of current phase (0 outside phases)
timer  out  TIMER_W  current tick count within phase
busy  out  1  high in any PHASE_k
phase_done  out  1  one-cycle pulse when a phase completes
seq_done  out  1  one-cycle pulse when the last phase completes

Behaviour:
- Reset is synchronous: state=IDLE (0...01), timer=0, phase_idx=0, busy=0, prescaler=0, pulses=0. All outputs are registered.
- IDLE: start=1 → PHASE_0 next cycle.
  - phase_len is latched into an internal copy on the same edge.
  - timer=0, prescaler=0.
- Changes to phase_len mid-sequence have no effect until the next start.
- Tick:
  - The prescaler counts 0..PRESCALE-1 on every non-paused cycle in a phase.
  - tick is asserted when prescaler==PRESCALE-1; the prescaler then wraps to 0.
  - With PRESCALE=1, tick is always asserted.
- PHASE_k on tick:
  - If timer < len_k: timer+1.
  - Else (timer == len_k): the phase ends. Next cycle timer=0, prescaler=0, phase_done=1 for one cycle.
- Phase duration is (len_k+1)*PRESCALE cycles. len_k=0 gives one tick.
- Phase advance:
  - k < NUM_PHASES-1 → PHASE_k+1.
  - k = NUM_PHASES-1: LOOP=0 → DONE with seq_done=1; LOOP=1 → PHASE_0 with seq_done=1.
- DONE: timer holds 0, busy=0. start=1 → PHASE_0, relatching phase_len. Otherwise DONE is held indefinitely.
- pause=1 in PHASE_k: timer and prescaler freeze and no phase ends. pause has no effect in IDLE/DONE.
- abort=1:
  - Any state → IDLE next cycle with timer=0, prescaler=0, phase_idx=0.
  - No phase_done/seq_done pulse is generated.
- Priority: reset > abort > pause > start > tick.
  - start while busy is ignored.
  - start and abort together → IDLE.
  - If a phase end coincides with abort, abort wins and no pulse is generated.
- Timer never wraps. len_k = 2^TIMER_W-1 is legal: the timer reaches all-ones, then the phase ends.
- state is always exactly one-hot. An illegal encoding recovers to IDLE on the next clock.

Decomposition:
- Shared package phase_timer_pkg holds:
  - state bit-index constants (ST_IDLE=0, ST_DONE=NUM_PHASES+1 as a function).
  - a clog2 helper function.
- One sub-module, tick_prescaler (PRESCALE parameter; clock, reset, en, clr → tick), is instantiated once.
- The FSM, phase_len latch and timer stay in phase_timer_fsm.

Test Plan:
1. Defaults, all phase_len=127, start pulse at cycle 5:
   - PHASE_0 from cycle 6; phase_done at cycle 134.
   - PHASE_1 entered; seq_done after 4*128 cycles; state=DONE (bit 5).
2. phase_len={3,0,2,1} (phase0=1, phase1=2, phase2=0, phase3=3), PRESCALE=3:
   - Phase durations are 6, 9, 3 and 12 cycles.
   - Four phase_done pulses; exactly one seq_done.
3. pause high for 10 cycles mid-PHASE_1 at timer=5:
   - timer stays 5 throughout the pause.
   - Phase end is delayed by exactly 10 cycles.
4. abort asserted on the same cycle the phase 2 timer reaches len:
   - IDLE next cycle; no phase_done; timer=0.
   - Then start and abort together → remains IDLE.
5. LOOP=1, NUM_PHASES=2, lens {1,1}:
   - Pattern PHASE_0, PHASE_1, PHASE_0...
   - seq_done every 4 cycles; state never DONE.
6. Reset asserted mid-PHASE_3 with timer=50:
   - Next cycle state=1, timer=0, busy=0, no pulses.
   - Change phase_len during a run: current run unaffected; next start uses the new values.

Source files
------------

// File: rtl/phase_timer_pkg.sv
// Shared constants and helpers for the phase timer sequencer: one-hot state
// bit positions, width helpers and the decoded state kind.
package phase_timer_pkg;

  localparam int ST_IDLE = 0;

  // Bit position of DONE in the one-hot state vector.
  function automatic int st_done(input int num_phases);
    return num_phases + 1;
  endfunction

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int ctr_width(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

  typedef enum logic [1:0] {
    KIND_IDLE  = 2'd0,
    KIND_PHASE = 2'd1,
    KIND_DONE  = 2'd2,
    KIND_BAD   = 2'd3
  } state_kind_e;

endpackage

// File: rtl/phase_timer_fsm_if.sv
// Control/status bundle of the phase timer: the controller drives start/pause/
// abort and the phase lengths, the sequencer returns state, timer and strobes.
interface phase_timer_fsm_if
  import phase_timer_pkg::*;
#(
  parameter int TIMER_W    = 8,
  parameter int NUM_PHASES = 4
) ();

  localparam int IDX_W = clog2(NUM_PHASES);

  logic                          start;
  logic                          pause;
  logic                          abort;
  logic [NUM_PHASES*TIMER_W-1:0] phase_len;
  logic [NUM_PHASES+1:0]         state;
  logic [IDX_W-1:0]              phase_idx;
  logic [TIMER_W-1:0]            timer;
  logic                          busy;
  logic                          phase_done;
  logic                          seq_done;

  modport master (
    output start, pause, abort, phase_len,
    input  state, phase_idx, timer, busy, phase_done, seq_done
  );

  modport slave (
    input  start, pause, abort, phase_len,
    output state, phase_idx, timer, busy, phase_done, seq_done
  );

endinterface

// File: rtl/phase_timer_fsm_tick_prescaler.sv
// Divides the clock into timer ticks: tick fires on the last count of every
// PRESCALE enabled cycles; clr restarts the count from zero.
module tick_prescaler
  import phase_timer_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = ctr_width(PRESCALE);

  logic [CNT_W-1:0] r_count;
  logic             w_wrap;

  assign w_wrap = (r_count == CNT_W'(PRESCALE - 1));
  assign tick   = en && w_wrap;

  // With PRESCALE=1 the count sits at zero and every enabled cycle ticks.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= w_wrap ? '0 : r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/phase_timer_fsm.sv
// Multi-phase sequencer: steps through NUM_PHASES timed phases with lengths
// latched at start, then parks in DONE or loops back to phase 0.
module phase_timer_fsm
  import phase_timer_pkg::*;
#(
  parameter int TIMER_W    = 8,
  parameter int NUM_PHASES = 4,
  parameter int PRESCALE   = 1,
  parameter int LOOP       = 0
) (
  input logic               clock,
  input logic               reset,
  phase_timer_fsm_if.slave  bus
);

  localparam int ST_W    = NUM_PHASES + 2;
  localparam int IDX_W   = clog2(NUM_PHASES);
  localparam int ST_DONE = st_done(NUM_PHASES);

  logic [ST_W-1:0]    r_state;
  logic [IDX_W-1:0]   r_phase_idx;
  logic [TIMER_W-1:0] r_timer;
  logic               r_busy;
  logic               r_phase_done;
  logic               r_seq_done;
  logic [TIMER_W-1:0] r_len [NUM_PHASES];

  state_kind_e        w_kind;
  logic [IDX_W-1:0]   w_cur_idx;
  logic [TIMER_W-1:0] w_cur_len;
  logic               w_in_phase;
  logic               w_last;
  logic               w_start_ok;
  logic               w_tick;
  logic               w_presc_en;
  logic               w_presc_clr;

  // Classify the one-hot state; anything not exactly one-hot is KIND_BAD.
  always_comb begin
    // NOTE: defaults first so no path through the decode infers a latch.
    w_kind    = KIND_BAD;
    w_cur_idx = '0;
    if (r_state == (ST_W'(1) << ST_IDLE)) begin
      w_kind = KIND_IDLE;
    end else if (r_state == (ST_W'(1) << ST_DONE)) begin
      w_kind = KIND_DONE;
    end else begin
      for (int k = 0; k < NUM_PHASES; k++) begin
        if (r_state == (ST_W'(1) << (k + 1))) begin
          w_kind    = KIND_PHASE;
          w_cur_idx = IDX_W'(k);
        end
      end
    end
  end

  assign w_cur_len  = r_len[w_cur_idx];
  assign w_in_phase = (w_kind == KIND_PHASE);
  assign w_last     = (w_cur_idx == IDX_W'(NUM_PHASES - 1));
  assign w_start_ok = bus.start && !bus.abort && !reset &&
                      ((w_kind == KIND_IDLE) || (w_kind == KIND_DONE));

  // Pause and abort both stall the prescaler, so neither can end a phase.
  assign w_presc_en  = w_in_phase && !bus.pause && !bus.abort;
  assign w_presc_clr = !w_in_phase || bus.abort;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .en    (w_presc_en),
    .clr   (w_presc_clr),
    .tick  (w_tick)
  );

  // NOTE: the length copy has no reset; it is only read after a start reloads it.
  always_ff @(posedge clock) begin
    if (w_start_ok) begin
      for (int k = 0; k < NUM_PHASES; k++) begin
        r_len[k] <= bus.phase_len[k*TIMER_W +: TIMER_W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_W'(1) << ST_IDLE;
      r_phase_idx  <= '0;
      r_timer      <= '0;
      r_busy       <= 1'b0;
      r_phase_done <= 1'b0;
      r_seq_done   <= 1'b0;
    end else begin
      r_phase_done <= 1'b0;
      r_seq_done   <= 1'b0;
      if (bus.abort) begin
        r_state     <= ST_W'(1) << ST_IDLE;
        r_phase_idx <= '0;
        r_timer     <= '0;
        r_busy      <= 1'b0;
      end else begin
        case (w_kind)
          KIND_IDLE, KIND_DONE: begin
            if (bus.start) begin
              r_state     <= ST_W'(2);
              r_phase_idx <= '0;
              r_timer     <= '0;
              r_busy      <= 1'b1;
            end
          end
          KIND_PHASE: begin
            if (w_tick) begin
              if (r_timer < w_cur_len) begin
                r_timer <= r_timer + TIMER_W'(1);
              end else begin
                r_timer      <= '0;
                r_phase_done <= 1'b1;
                if (!w_last) begin
                  r_state     <= r_state << 1;
                  r_phase_idx <= w_cur_idx + IDX_W'(1);
                end else begin
                  r_seq_done  <= 1'b1;
                  r_phase_idx <= '0;
                  if (LOOP != 0) begin
                    r_state <= ST_W'(2);
                  end else begin
                    r_state <= ST_W'(1) << ST_DONE;
                    r_busy  <= 1'b0;
                  end
                end
              end
            end
          end
          default: begin
            r_state     <= ST_W'(1) << ST_IDLE;
            r_phase_idx <= '0;
            r_timer     <= '0;
            r_busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.state      = r_state;
  assign bus.phase_idx  = r_phase_idx;
  assign bus.timer      = r_timer;
  assign bus.busy       = r_busy;
  assign bus.phase_done = r_phase_done;
  assign bus.seq_done   = r_seq_done;

endmodule
